// File: rtl/beep_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beep_driver_pkg
// Brief    : State encoding, 12 MHz timing defaults and width helpers for
//            the beep driver.
// Revision : 1.0 - initial release
// ============================================================================
package beep_driver_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BEEP = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    typedef logic [1:0] state_t;

    localparam int c_TONE_HALF_DEF = 6000;
    localparam int c_SHORT_LEN_DEF = 1200000;
    localparam int c_LONG_LEN_DEF  = 4800000;
    localparam int c_GAP_LEN_DEF   = 600000;
    localparam int c_MAX_PEND_DEF  = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int cnt_width(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/beep_driver_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : beep_driver_tone_gen
// Brief    : TONE_HALF square-wave divider; starts high after clear, 0 when
//            disabled.
// Revision : 1.0 - initial release
// ============================================================================
module beep_driver_tone_gen
    import beep_driver_pkg::*;
#(
    parameter int TONE_HALF = c_TONE_HALF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wave
);

    localparam int                c_TW   = cnt_width(TONE_HALF);
    localparam logic [c_TW-1:0]   c_TMAX = c_TW'(TONE_HALF - 1);

    logic [c_TW-1:0] r_cnt;
    logic            r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (en) begin
            if (r_cnt == c_TMAX) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign wave = en & ~r_phase;

endmodule
`default_nettype wire

// File: rtl/beep_driver.sv
`default_nettype none
// ============================================================================
// Module   : beep_driver
// Brief    : Queues short/long beep pulses in saturating counters and plays
//            them one at a time as a tone burst followed by a silent gap.
// Revision : 1.0 - initial release
// ============================================================================
module beep_driver
    import beep_driver_pkg::*;
#(
    parameter int TONE_HALF = c_TONE_HALF_DEF,
    parameter int SHORT_LEN = c_SHORT_LEN_DEF,
    parameter int LONG_LEN  = c_LONG_LEN_DEF,
    parameter int GAP_LEN   = c_GAP_LEN_DEF,
    parameter int MAX_PEND  = c_MAX_PEND_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_short,
    input  logic req_long,
    output logic buzzer,
    output logic busy,
    output logic drop
);

    localparam int              c_DW   = cnt_width(max3(SHORT_LEN, LONG_LEN, GAP_LEN));
    localparam int              c_PW   = cnt_width(MAX_PEND + 1);
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(MAX_PEND);

    state_t          r_state, w_state_nxt;
    logic [c_DW-1:0] r_dur, w_dur_nxt;
    logic [c_DW-1:0] r_gap, w_gap_nxt;
    logic [c_PW-1:0] r_pend_s, w_pend_s_nxt;
    logic [c_PW-1:0] r_pend_l, w_pend_l_nxt;
    logic            r_drop;
    logic            w_deq_s, w_deq_l;
    logic            w_ovf_s, w_ovf_l;
    logic            w_in_beep, w_wave;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_dur    <= '0;
            r_gap    <= '0;
            r_pend_s <= '0;
            r_pend_l <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dur    <= w_dur_nxt;
            r_gap    <= w_gap_nxt;
            r_pend_s <= w_pend_s_nxt;
            r_pend_l <= w_pend_l_nxt;
            r_drop   <= w_ovf_s | w_ovf_l;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_gap_nxt   = r_gap;
        w_deq_s     = 1'b0;
        w_deq_l     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_pend_l != '0) begin
                    w_deq_l     = 1'b1;
                    w_dur_nxt   = c_DW'(LONG_LEN - 1);
                    w_state_nxt = c_ST_BEEP;
                end else if (r_pend_s != '0) begin
                    w_deq_s     = 1'b1;
                    w_dur_nxt   = c_DW'(SHORT_LEN - 1);
                    w_state_nxt = c_ST_BEEP;
                end
            end
            c_ST_BEEP: begin
                if (r_dur == '0) begin
                    w_gap_nxt   = c_DW'(GAP_LEN - 1);
                    w_state_nxt = c_ST_GAP;
                end else begin
                    w_dur_nxt = r_dur - 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // A request coinciding with a dequeue of its own kind leaves the count as is.
    always_comb begin
        w_ovf_s      = req_short && !w_deq_s && (r_pend_s == c_PMAX);
        w_ovf_l      = req_long  && !w_deq_l && (r_pend_l == c_PMAX);
        w_pend_s_nxt = r_pend_s;
        w_pend_l_nxt = r_pend_l;
        if (req_short && !w_deq_s && !w_ovf_s) begin
            w_pend_s_nxt = r_pend_s + 1'b1;
        end else if (!req_short && w_deq_s) begin
            w_pend_s_nxt = r_pend_s - 1'b1;
        end
        if (req_long && !w_deq_l && !w_ovf_l) begin
            w_pend_l_nxt = r_pend_l + 1'b1;
        end else if (!req_long && w_deq_l) begin
            w_pend_l_nxt = r_pend_l - 1'b1;
        end
    end

    assign w_in_beep = (r_state == c_ST_BEEP);

    beep_driver_tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_in_beep),
        .en   (w_in_beep),
        .wave (w_wave)
    );

    assign buzzer = w_wave;
    assign busy   = (r_state != c_ST_IDLE) || (r_pend_s != '0) || (r_pend_l != '0);
    assign drop   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_beep_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_beep_driver
// Brief    : Scoreboard bench for beep_driver against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beep_driver;

    localparam int TH = 2;
    localparam int SL = 8;
    localparam int LL = 16;
    localparam int GL = 4;
    localparam int MP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_short = 1'b0;
    logic req_long = 1'b0;
    logic buzzer, busy, drop;

    beep_driver #(
        .TONE_HALF (TH),
        .SHORT_LEN (SL),
        .LONG_LEN  (LL),
        .GAP_LEN   (GL),
        .MAX_PEND  (MP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_short (req_short),
        .req_long  (req_long),
        .buzzer    (buzzer),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [2:0] exp_q[$];

    // Timeline model: pending counts plus start/length of the latest beep and
    // the first cycle at which the player is free to dequeue again.
    int m_ps, m_pl, m_s, m_len, m_free;
    bit m_drop;

    task automatic model_reset();
        m_ps = 0; m_pl = 0; m_s = -1000; m_len = 0; m_free = 0; m_drop = 0;
    endtask

    function automatic logic [2:0] model_out(input int c);
        logic bz, bs;
        bz = (c >= m_s && c < m_s + m_len) ? ((((c - m_s) / TH) % 2) == 0) : 1'b0;
        bs = (c < m_free) || (m_ps > 0) || (m_pl > 0);
        return {bz, bs, m_drop};
    endfunction

    task automatic model_step(input int c, input bit rs, input bit rl);
        bit idle, dl, ds, os, ol;
        idle = (c >= m_free);
        dl = idle && (m_pl > 0);
        ds = idle && !dl && (m_ps > 0);
        if (dl) begin m_s = c + 1; m_len = LL; m_free = c + 1 + LL + GL; end
        if (ds) begin m_s = c + 1; m_len = SL; m_free = c + 1 + SL + GL; end
        os = rs && !ds && (m_ps == MP);
        ol = rl && !dl && (m_pl == MP);
        if (rs && !ds && !os) m_ps++;
        else if (!rs && ds) m_ps--;
        if (rl && !dl && !ol) m_pl++;
        else if (!rl && dl) m_pl--;
        m_drop = os || ol;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic tick(input bit rs, input bit rl, input bit r);
        req_short = rs & ~r;
        req_long  = rl & ~r;
        if (r) begin
            model_reset();
            exp_q.push_back(3'b000);
            rst = 1'b1;
            #1;
            n_cmp++;
            if ({buzzer, busy, drop} !== 3'b000) begin
                n_fail++;
                $display("FAIL async_rst cyc=%0d buzzer/busy/drop got %b want 000",
                         cyc, {buzzer, busy, drop});
            end
        end else begin
            rst = 1'b0;
            exp_q.push_back(model_out(cyc));
            model_step(cyc, rs, rl);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({buzzer, busy, drop} !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d buzzer/busy/drop got %b want %b",
                         cyc, {buzzer, busy, drop}, e);
            end
        end
    end

    initial begin
        int dens, rst_hold;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        idle_n(5);

        // Single short beep
        tick(1'b1, 1'b0, 1'b0);
        idle_n(20);

        // Long has priority over a simultaneous short
        tick(1'b1, 1'b1, 1'b0);
        idle_n(40);

        // Short saturation during a beep
        tick(1'b1, 1'b0, 1'b0);
        idle_n(2);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        idle_n(60);

        // Both kinds overflowing together
        tick(1'b0, 1'b1, 1'b0);
        idle_n(2);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
        idle_n(130);

        // Reset on the third BEEP cycle with two shorts pending
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        idle_n(30);

        // Request in the same cycle a pending short is dequeued
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle_n(40);

        // Randomized traffic with occasional resets
        rst_hold = 0;
        dens = 8;
        for (int i = 0; i < 2400; i++) begin
            bit rs, rl;
            if (i % 200 == 0) dens = (i % 600 == 0) ? 2 : ((i % 400 == 0) ? 24 : 6);
            rs = ($urandom_range(0, dens - 1) == 0);
            rl = ($urandom_range(0, 2 * dens - 1) == 0);
            if (rst_hold == 0 && $urandom_range(0, 399) == 0) rst_hold = 2;
            tick(rs, rl, rst_hold != 0);
            if (rst_hold != 0) rst_hold--;
        end
        idle_n(120);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beep_driver.md
Name: beep_driver

Overview:
- Output-side counterpart to the key debounce stage. Debounce turns a noisy level into a one-cycle pulse; this block turns one-cycle pulses from the taximeter control logic into clean buzzer waveforms with a guaranteed minimum width.
- Accepts short-beep and long-beep requests and queues them in saturating pending counters.
- Plays them one at a time: a square-wave tone, then a silent gap. Sits between the control FSM (key acknowledge, fare-step alerts) and the buzzer pin.

Parameters:
- TONE_HALF, 6000: clock cycles per tone half-period (1 kHz at 12 MHz).
- SHORT_LEN, 1200000: beep duration in cycles for a short request (100 ms).
- LONG_LEN, 4800000: beep duration in cycles for a long request (400 ms).
- GAP_LEN, 600000: silent cycles after every beep (50 ms).
- MAX_PEND, 7: maximum queued requests per kind (counter width = $clog2(MAX_PEND+1)).

Ports:
- clk, input, 1: system clock (12 MHz).
- rst, input, 1: asynchronous reset, active-high.
- req_short, input, 1: one-cycle request for a short beep.
- req_long, input, 1: one-cycle request for a long beep.
- buzzer, output, 1: tone output, high = driven.
- busy, output, 1: high while in BEEP or GAP, or while any request is pending.
- drop, output, 1: one-cycle pulse when a request is lost to saturation.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst is high, all state clears asynchronously:
  - state = IDLE; both pending counters = 0; duration, tone and gap counters = 0.
  - buzzer = 0, busy = 0, drop = 0.
- Reset mid-beep silences buzzer immediately and discards the queue.
- Request capture (every cycle):
  - A high req_short increments pend_s; a high req_long increments pend_l.
  - Both may be high in the same cycle; each is counted in its own counter.
  - If the same-cycle dequeue of a kind coincides with a request of that kind, that counter is unchanged.
  - If a counter is at MAX_PEND and a request of that kind arrives with no same-cycle dequeue, the counter holds and drop pulses high for exactly 1 cycle. If both kinds overflow in the same cycle, drop is still a single 1-cycle pulse.
- FSM states: IDLE, BEEP, GAP.
  - IDLE: if pend_l > 0, dequeue long (pend_l - 1), load dur = LONG_LEN-1, go to BEEP. Otherwise, if pend_s > 0, dequeue short, load dur = SHORT_LEN-1, go to BEEP. Long requests have priority.
  - A request arriving in IDLE is dequeued the next cycle. First buzzer high occurs 2 cycles after the req edge (capture cycle + dequeue cycle).
  - BEEP:
    - buzzer starts at 1 on the first BEEP cycle.
    - The tone counter counts 0..TONE_HALF-1; buzzer toggles on wrap.
    - dur decrements every cycle. When dur == 0: go to GAP with gap counter = GAP_LEN-1 and buzzer forced to 0.
    - Beep width is exactly SHORT_LEN or LONG_LEN cycles.
  - GAP:
    - buzzer = 0; the gap counter decrements. When it reaches 0, go to IDLE.
    - IDLE may then dequeue in the following cycle, so back-to-back beeps are separated by GAP_LEN+1 silent cycles.
- The tone counter resets to 0 on every BEEP entry, so every beep has identical phase.
- busy = (state != IDLE) | (pend_s != 0) | (pend_l != 0), registered-state based. It is high from the cycle after the first request until the last GAP completes.
- Counter widths sized with $clog2 of the largest length parameter. No counter ever wraps past 0; terminal-count checks are on == 0.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BEEP=2'd1, GAP=2'd2) and the default timing constants at 12 MHz.
- One natural sub-module, tone_gen: a TONE_HALF divider with a clear input, producing the square wave while enabled and 0 when disabled.

Test Plan:
- Use TONE_HALF=2, SHORT_LEN=8, LONG_LEN=16, GAP_LEN=4, MAX_PEND=3 for all scenarios.
- Single short: req_short pulse at cycle 10 -> buzzer high at cycle 12, pattern 1,1,0,0,1,1,0,0 over cycles 12-19, then 0; busy high cycles 11-23, low from 24.
- Long priority: req_short and req_long in the same cycle -> long beep (16 cycles) first, 5 silent cycles, then short beep (8 cycles); drop stays 0.
- Saturation: 5 req_short pulses on consecutive cycles while in BEEP -> pend_s saturates at 3; drop pulses once for each of the 2 excess requests; exactly 1+3 beeps are played in total.
- Reset mid-operation: rst asserted at the 3rd BEEP cycle with pend_s = 2 -> buzzer = 0, busy = 0 asynchronously; no beep after rst release until a new request.
- Dequeue/request collision: req_short arrives in the same IDLE cycle that a pending short is dequeued -> pend_s unchanged; both beeps are played, separated by a 5-cycle gap.
